// File: rtl/cic_decim.sv
// cic_decim: ORDER-stage CIC decimator by 2^DECIM_LOG2; out_valid rises 1 clk after the tick edge; no backpressure.
// Define CIC_ROUND_EN for round-half-up with saturation when narrowing to OUT_W; otherwise LSBs are truncated.
module cic_decim #(
  parameter int ORDER      = 3,
  parameter int DECIM_LOG2 = 4,
  parameter int DIFF_DLY   = 1,
  parameter int IN_W       = 1,
  parameter int IN_SIGNED  = 0,
  parameter int OUT_W      = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [IN_W-1:0]       in,
  output logic [OUT_W-1:0]      out,
  output logic                  out_valid,
  output logic [DECIM_LOG2-1:0] phase
);
  localparam int W  = IN_W + ((IN_SIGNED != 0) ? 0 : 1) + ORDER * (DECIM_LOG2 + DIFF_DLY - 1);
  localparam int SH = W - OUT_W;

  logic [W-1:0]          in_ext;
  logic [W-1:0]          integ_q [ORDER];
  logic [W-1:0]          integ_d [ORDER];
  logic [W-1:0]          dly_q   [ORDER][DIFF_DLY];
  logic [W-1:0]          dly_d   [ORDER][DIFF_DLY];
  logic [W-1:0]          comb_in [ORDER+1];
  logic [W-1:0]          y;
  logic [OUT_W-1:0]      y_out;
  logic [OUT_W-1:0]      out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic [DECIM_LOG2-1:0] phase_q, phase_d;
  logic                  tick;

  generate
    if (IN_SIGNED != 0) begin : g_sext
      assign in_ext = {{(W-IN_W){in[IN_W-1]}}, in};
    end else begin : g_zext
      assign in_ext = {{(W-IN_W){1'b0}}, in};
    end
  endgenerate

  // Integrators and phase advance only on accepted samples.
  always_comb begin
    phase_d = phase_q;
    integ_d = integ_q;
    tick    = in_valid && (&phase_q);
    if (in_valid) begin
      phase_d    = phase_q + DECIM_LOG2'(1);
      integ_d[0] = integ_q[0] + in_ext;
      for (int k = 1; k < ORDER; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
    end
  end

  // Comb chain fed by the integrator value that includes the sample accepted on this edge.
  always_comb begin
    dly_d      = dly_q;
    comb_in[0] = integ_d[ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      comb_in[k+1] = comb_in[k] - dly_q[k][DIFF_DLY-1];
    end
    if (tick) begin
      for (int k = 0; k < ORDER; k++) begin
        dly_d[k][0] = comb_in[k];
        for (int j = 1; j < DIFF_DLY; j++) begin
          dly_d[k][j] = dly_q[k][j-1];
        end
      end
    end
  end

  assign y = comb_in[ORDER];

  generate
    if (SH == 0) begin : g_pass
      assign y_out = y;
    end else begin : g_shape
`ifdef CIC_ROUND_EN
      localparam logic [W:0]       HALF    = (W+1)'(1) << (SH - 1);
      localparam logic [OUT_W:0]   ONE_O   = (OUT_W+1)'(1);
      localparam logic [OUT_W-1:0] MAX_POS = OUT_W'((ONE_O << (OUT_W - 1)) - ONE_O);
      logic [W:0]     rsum;
      logic [OUT_W:0] rsh;
      logic [SH-1:0]  unused_lsb;
      assign rsum       = {y[W-1], y} + HALF;
      assign rsh        = rsum[W:SH];
      assign unused_lsb = rsum[SH-1:0];
      // Only a positive overflow is possible since the rounding offset is positive.
      assign y_out      = (rsh[OUT_W] != rsh[OUT_W-1]) ? MAX_POS : rsh[OUT_W-1:0];
`else
      logic [SH-1:0] unused_lsb;
      assign y_out      = y[W-1:SH];
      assign unused_lsb = y[SH-1:0];
`endif
    end
  endgenerate

  always_comb begin
    out_valid_d = tick;
    out_d       = tick ? y_out : out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= '0;
        for (int j = 0; j < DIFF_DLY; j++) begin
          dly_q[k][j] <= '0;
        end
      end
    end else begin
      phase_q     <= phase_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      integ_q     <= integ_d;
      dly_q       <= dly_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign phase     = phase_q;
endmodule

// File: tb/tb_cic_decim.sv
// Directed bench for cic_decim: default build plus signed, narrowed and first-order variants.
module tb_cic_decim;
  logic clk, reset;

  logic        d_vld;  logic [0:0] d_in;  logic [13:0] d_out;  logic d_ov;  logic [3:0] d_ph;
  logic        s_vld;  logic [3:0] s_in;  logic [15:0] s_out;  logic s_ov;  logic [3:0] s_ph;
  logic        t_vld;  logic [0:0] t_in;  logic [9:0]  t_out;  logic t_ov;  logic [3:0] t_ph;
  logic        r_vld;  logic [0:0] r_in;  logic [1:0]  r_out;  logic r_ov;  logic [3:0] r_ph;

  int tests, fails, ph;
  logic [13:0] step_seq [7];

`ifdef CIC_ROUND_EN
  localparam logic [1:0] HALF_EXP = 2'd1;
`else
  localparam logic [1:0] HALF_EXP = 2'd0;
`endif

  cic_decim dut_def (
    .clk(clk), .reset(reset), .in_valid(d_vld), .in(d_in),
    .out(d_out), .out_valid(d_ov), .phase(d_ph));

  cic_decim #(.ORDER(3), .DECIM_LOG2(4), .DIFF_DLY(1), .IN_W(4), .IN_SIGNED(1), .OUT_W(16)) dut_s (
    .clk(clk), .reset(reset), .in_valid(s_vld), .in(s_in),
    .out(s_out), .out_valid(s_ov), .phase(s_ph));

  cic_decim #(.OUT_W(10)) dut_o10 (
    .clk(clk), .reset(reset), .in_valid(t_vld), .in(t_in),
    .out(t_out), .out_valid(t_ov), .phase(t_ph));

  cic_decim #(.ORDER(1), .DECIM_LOG2(4), .DIFF_DLY(1), .IN_W(1), .IN_SIGNED(0), .OUT_W(2)) dut_o1 (
    .clk(clk), .reset(reset), .in_valid(r_vld), .in(r_in),
    .out(r_out), .out_valid(r_ov), .phase(r_ph));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    d_vld = 1'b0; s_vld = 1'b0; t_vld = 1'b0; r_vld = 1'b0;
    repeat (n) step_clk();
    reset = 1'b0;
    ph = 0;
  endtask

  task automatic test_reset();
    do_reset(10);
    tests++; if (d_out !== 14'd0) begin fails++; $display("FAIL reset_out got %h want 0", d_out); end
    tests++; if (d_ov !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", d_ov); end
    tests++; if (d_ph !== 4'd0) begin fails++; $display("FAIL reset_phase got %0d want 0", d_ph); end
    tests++; if (s_out !== 16'd0) begin fails++; $display("FAIL reset_s_out got %h want 0", s_out); end
    tests++; if (r_out !== 2'd0 || r_ph !== 4'd0) begin fails++; $display("FAIL reset_o1 got %0d/%0d want 0/0", r_out, r_ph); end
  endtask

  task automatic test_zero();
    logic exp_v;
    d_vld = 1'b1; d_in = 1'b0;
    for (int c = 0; c < 512; c++) begin
      exp_v = (ph == 15);
      ph = (ph + 1) % 16;
      step_clk();
      tests++; if (d_ov !== exp_v) begin fails++; $display("FAIL zero_valid cyc %0d got %b want %b", c, d_ov, exp_v); end
      tests++; if (d_ph !== 4'(ph)) begin fails++; $display("FAIL zero_phase cyc %0d got %0d want %0d", c, d_ph, ph); end
      tests++; if (d_out !== 14'd0) begin fails++; $display("FAIL zero_out cyc %0d got %h want 0", c, d_out); end
    end
  endtask

  task automatic test_step();
    logic exp_v;
    logic [13:0] prev;
    int n;
    n = 0; prev = '0;
    d_vld = 1'b1; d_in = 1'b1;
    for (int c = 0; c < 112; c++) begin
      exp_v = (ph == 15);
      ph = (ph + 1) % 16;
      step_clk();
      tests++; if (d_ov !== exp_v) begin fails++; $display("FAIL step_valid cyc %0d got %b want %b", c, d_ov, exp_v); end
      if (d_ov === 1'b1) begin
        if (n < 7) step_seq[n] = d_out;
        n++;
        tests++; if (d_out < prev) begin fails++; $display("FAIL step_monotonic strobe %0d got %h after %h", n, d_out, prev); end
        prev = d_out;
        if (n >= 4) begin
          tests++; if (d_out !== 14'h1000) begin fails++; $display("FAIL step_settled strobe %0d got %h want 1000", n, d_out); end
        end
      end
    end
    tests++; if (n != 7) begin fails++; $display("FAIL step_count got %0d want 7", n); end
    d_vld = 1'b0;
  endtask

  task automatic test_gaps();
    logic exp_v;
    int n, cyc;
    do_reset(1);
    n = 0; cyc = 0;
    d_in = 1'b1;
    while (n < 7 && cyc < 3000) begin
      d_vld = 1'($urandom_range(0, 1));
      exp_v = d_vld && (ph == 15);
      if (d_vld) ph = (ph + 1) % 16;
      step_clk();
      cyc++;
      tests++; if (d_ov !== exp_v) begin fails++; $display("FAIL gaps_valid cyc %0d got %b want %b", cyc, d_ov, exp_v); end
      if (d_ov === 1'b1) begin
        tests++; if (d_out !== step_seq[n]) begin fails++; $display("FAIL gaps_out strobe %0d got %h want %h", n, d_out, step_seq[n]); end
        n++;
      end
    end
    tests++; if (n != 7) begin fails++; $display("FAIL gaps_count got %0d want 7 (cycle budget)", n); end
    d_vld = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic exp_v;
    int n;
    do_reset(1);
    d_vld = 1'b1; d_in = 1'b1;
    for (int c = 0; c < 39; c++) begin
      ph = (ph + 1) % 16;
      step_clk();
    end
    tests++; if (d_ph !== 4'd7) begin fails++; $display("FAIL mid_phase got %0d want 7", d_ph); end
    reset = 1'b1;
    step_clk();
    reset = 1'b0;
    ph = 0;
    tests++; if (d_out !== 14'd0) begin fails++; $display("FAIL mid_reset_out got %h want 0", d_out); end
    tests++; if (d_ov !== 1'b0) begin fails++; $display("FAIL mid_reset_valid got %b want 0", d_ov); end
    tests++; if (d_ph !== 4'd0) begin fails++; $display("FAIL mid_reset_phase got %0d want 0", d_ph); end
    n = 0;
    for (int c = 0; c < 112; c++) begin
      exp_v = (ph == 15);
      ph = (ph + 1) % 16;
      step_clk();
      tests++; if (d_ov !== exp_v) begin fails++; $display("FAIL mid_valid cyc %0d got %b want %b", c, d_ov, exp_v); end
      if (d_ov === 1'b1 && n < 7) begin
        tests++; if (d_out !== step_seq[n]) begin fails++; $display("FAIL mid_out strobe %0d got %h want %h", n, d_out, step_seq[n]); end
        n++;
      end
    end
    tests++; if (n != 7) begin fails++; $display("FAIL mid_count got %0d want 7", n); end
    d_vld = 1'b0;
  endtask

  task automatic test_signed();
    int n;
    n = 0;
    s_vld = 1'b1; s_in = 4'b1000;
    for (int c = 0; c < 80; c++) begin
      step_clk();
      if (s_ov === 1'b1) begin
        n++;
        if (n >= 4) begin
          tests++; if (s_out !== 16'h8000) begin fails++; $display("FAIL signed_out strobe %0d got %h want 8000", n, s_out); end
        end
      end
    end
    tests++; if (n != 5) begin fails++; $display("FAIL signed_count got %0d want 5", n); end
    s_vld = 1'b0;
  endtask

  task automatic test_out_shape();
    int n;
    logic [1:0] exp_r;
    n = 0;
    t_vld = 1'b1; t_in = 1'b1;
    for (int c = 0; c < 80; c++) begin
      step_clk();
      if (t_ov === 1'b1) begin
        n++;
        if (n >= 4) begin
          tests++; if (t_out !== 10'd256) begin fails++; $display("FAIL narrow_out strobe %0d got %0d want 256", n, t_out); end
        end
      end
    end
    tests++; if (n != 5) begin fails++; $display("FAIL narrow_count got %0d want 5", n); end
    t_vld = 1'b0;

    // Half-density blocks give y = 8 (exactly half an output LSB); a full block gives y = 16.
    n = 0;
    r_vld = 1'b1;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 16; i++) begin
        r_in = (b == 3 || i < 8) ? 1'b1 : 1'b0;
        step_clk();
        if (r_ov === 1'b1) begin
          exp_r = (n < 3) ? HALF_EXP : 2'd1;
          tests++; if (r_out !== exp_r) begin fails++; $display("FAIL order1_out strobe %0d got %0d want %0d", n, r_out, exp_r); end
          n++;
        end
      end
    end
    tests++; if (n != 4) begin fails++; $display("FAIL order1_count got %0d want 4", n); end
    r_vld = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; ph = 0;
    reset = 1'b1;
    d_vld = 1'b0; d_in = '0;
    s_vld = 1'b0; s_in = '0;
    t_vld = 1'b0; t_in = '0;
    r_vld = 1'b0; r_in = '0;
    test_reset();
    test_zero();
    test_step();
    test_gaps();
    test_mid_reset();
    test_signed();
    test_out_shape();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cic_decim.md
Name: cic_decim

Overview:
Parametrised N-stage CIC decimation filter, successor to the fixed 3rd-order, 1-bit-in / 14-bit-out CIC3 decimator.
- Generalised in order, decimation ratio, differential delay, input width and input signedness.
- Adds an input qualifier, an output valid strobe and selectable output truncation.
- Sits between a sigma-delta modulator bitstream (or multi-bit ADC) and downstream digital filtering.

Parameters:
ORDER, 3, number of integrator and comb stages (1..6).
DECIM_LOG2, 4, log2 of decimation ratio R; R = 2^DECIM_LOG2 (1..8).
DIFF_DLY, 1, comb differential delay M (1 or 2).
IN_W, 1, input sample width (1..16).
IN_SIGNED, 0, 0 = input unsigned (zero-extended by 1 bit), 1 = two's complement.
OUT_W, 14, output width; must be <= W.
Derived: W = IN_W + (IN_SIGNED ? 0 : 1) + ORDER*(DECIM_LOG2 + DIFF_DLY - 1). Defaults give W = 14.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous reset, active-high.
in_valid  in  1  qualifies in; sample is accepted on a rising clk edge with in_valid = 1.
in  in  IN_W  input sample.
out  out  OUT_W  decimated output, two's complement.
out_valid  out  1  one-cycle strobe; out is new on this cycle.
phase  out  DECIM_LOG2  count of samples accepted in the current decimation block.

Behaviour:
- Reset: reset = 1 sampled on clk clears all integrators, comb delay registers, phase, out and out_valid to 0. Reset takes priority over everything, including mid-block. After reset the first block starts at phase 0.
- Input extension:
  - Unsigned input is zero-extended to W.
  - Signed input is sign-extended to W.
  - Default IN_W = 1 maps in = 1 to +1 and in = 0 to 0.
- Integrators:
  - ORDER cascaded W-bit accumulators. Each updates only on an accepted sample.
  - Stage 1 adds the extended input; stage k adds the registered output of stage k-1.
  - Modular wrap-around on overflow is intended and required; no saturation inside the filter.
- Decimation counter:
  - phase increments on each accepted sample. When an accepted sample arrives with phase = R-1, phase wraps to 0 and a decimation tick is generated.
  - in_valid = 0 holds all state; gaps anywhere produce output identical to a gapless run of the same accepted samples.
- Combs:
  - On a tick, ORDER cascaded W-bit differences are evaluated from the last-stage integrator value, including the accepted sample.
  - Each comb stage computes c_k = x_k - x_k[-M], where x_k[-M] is the stage input from M ticks earlier.
  - Comb delay registers update only on ticks. Subtraction is modulo 2^W.
- Output:
  - Comb result is registered into out, and out_valid = 1 for exactly one clk, the cycle after the tick edge. Latency is 1 clk from the accepting edge.
  - out holds its value between strobes.
  - With OUT_W = W the result is passed through. With OUT_W < W the W-OUT_W LSBs are dropped (see Optional Feature).
- DC gain = (R*M)^ORDER; defaults give 4096.
- Back-to-back ticks are impossible for R >= 2. For R = 1 (DECIM_LOG2 = 0 is not allowed) there is no such case.

Optional Feature:
CIC_ROUND_EN:
- Defined: when OUT_W < W, out = (y + 2^(W-OUT_W-1)) >>> (W-OUT_W), round-half-up. The result saturates to the max positive OUT_W value if rounding overflows.
- Undefined: plain truncation (arithmetic shift right, drop LSBs).
- When OUT_W = W the two are identical. Latency is unchanged in both cases.

Test Plan:
1. Defaults, reset 10 cycles, in_valid = 1, in = 0 for 512 cycles -> every out_valid strobe exactly every 16 clk with out = 0; phase counts 0..15 repeating.
2. Defaults, step in 0 -> 1 at a block boundary, held -> out non-decreasing and equal to 4096 (0x1000) by the 4th out_valid after the step, then constant.
3. Same as 2 with in_valid toggled pseudo-randomly (about 50%) -> sequence of out values identical to test 2; out_valid only one cycle after a tick.
4. IN_SIGNED = 1, IN_W = 4 (W = 16, OUT_W = 16), constant in = -8 -> settled out = -32768 (0x8000); integrators wrap without corrupting the result.
5. Defaults, step running; assert reset for 1 cycle mid-block at phase = 7 -> next cycle out = 0, out_valid = 0, phase = 0; post-reset step response repeats test 2 exactly.
6. OUT_W = 10, step input, with and without CIC_ROUND_EN -> settled out = 256 in both. Then ORDER = 1, in = 1 for 8 of 16 samples per block -> truncate 0, round 1.
